// File: rtl/mips_multicycle_controller_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The controller drives the strobes/selects; the datapath supplies opcode fields and the zero flag.
interface mips_multicycle_controller_if;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       zero;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       PCWrite;
    logic       Branch;
    logic       PCEn;
    logic       ALUSrcA;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       IllegalOp;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic [2:0] ALUControl;

    modport master (
        input  Op, Funct, zero,
        output IorD, MemWrite, IRWrite, PCWrite, Branch, PCEn, ALUSrcA,
               RegDst, MemtoReg, RegWrite, IllegalOp, ALUSrcB, PCSrc, ALUControl
    );

    modport slave (
        output Op, Funct, zero,
        input  IorD, MemWrite, IRWrite, PCWrite, Branch, PCEn, ALUSrcA,
               RegDst, MemtoReg, RegWrite, IllegalOp, ALUSrcB, PCSrc, ALUControl
    );
endinterface

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS Moore controller with registered outputs and a sticky illegal-op flag.
// Define MIPS_MUL_EN to decode Funct 011000 as a multiply R-type.
module mips_multicycle_controller (
    input  logic clk,
    input  logic rst_n,
    mips_multicycle_controller_if.master io_ctrl
);

    localparam int unsigned ALU_W = 3;
    localparam int unsigned SEL_W = 2;

    localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(3'b000);
    localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(3'b001);
    localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(3'b010);
    localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(3'b100);
    localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(3'b110);
`ifdef MIPS_MUL_EN
    localparam logic [ALU_W-1:0] ALU_MUL = ALU_W'(3'b101);
`endif

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
    } state_t;

    typedef struct packed {
        logic             iord;
        logic             mem_write;
        logic             ir_write;
        logic             pc_write;
        logic             branch;
        logic             alu_src_a;
        logic             reg_dst;
        logic             mem_to_reg;
        logic             reg_write;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] pc_src;
        logic [ALU_W-1:0] alu_ctrl;
    } ctrl_t;

    state_t           r_state;
    state_t           w_next;
    ctrl_t            r_ctrl;
    logic             r_illegal;
    logic             w_illegal_set;
    logic             w_funct_ok;
    logic [ALU_W-1:0] w_exec_alu;

    // Moore output table; EXECUTE takes its ALU op from the Funct decode.
    function automatic ctrl_t state_outputs(input state_t s, input logic [ALU_W-1:0] exec_alu);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = SEL_W'(2'b01);
                c.alu_ctrl  = ALU_ADD;
            end
            S_DECODE: begin
                c.alu_src_b = SEL_W'(2'b11);
                c.alu_ctrl  = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SEL_W'(2'b10);
                c.alu_ctrl  = ALU_ADD;
            end
            S_MEMRD: c.iord = 1'b1;
            S_MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_ctrl  = exec_alu;
            end
            S_ALUWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_ctrl  = ALU_SUB;
                c.pc_src    = SEL_W'(2'b01);
                c.branch    = 1'b1;
            end
            S_ADDIWB: c.reg_write = 1'b1;
            S_JUMP: begin
                c.pc_src   = SEL_W'(2'b10);
                c.pc_write = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    // R-type function field to ALU operation.
    always_comb begin
        w_funct_ok = 1'b1;
        w_exec_alu = ALU_ADD;
        case (io_ctrl.Funct)
            6'b100000: w_exec_alu = ALU_ADD;
            6'b100010: w_exec_alu = ALU_SUB;
            6'b100100: w_exec_alu = ALU_AND;
            6'b100101: w_exec_alu = ALU_OR;
            6'b101010: w_exec_alu = ALU_SLT;
`ifdef MIPS_MUL_EN
            6'b011000: w_exec_alu = ALU_MUL;
`endif
            default:   w_funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_next        = S_FETCH;
        w_illegal_set = 1'b0;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (io_ctrl.Op)
                    6'b100011, 6'b101011: w_next = S_MEMADR;
                    6'b000000:            w_next = S_EXECUTE;
                    6'b000100:            w_next = S_BRANCH;
                    6'b001000:            w_next = S_ADDIEX;
                    6'b000010:            w_next = S_JUMP;
                    default:              w_illegal_set = 1'b1;
                endcase
            end
            S_MEMADR:  w_next = (io_ctrl.Op == 6'b100011) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   w_next = S_MEMWB;
            S_EXECUTE: begin
                w_next        = w_funct_ok ? S_ALUWB : S_FETCH;
                w_illegal_set = ~w_funct_ok;
            end
            S_ADDIEX:  w_next = S_ADDIWB;
            default:   w_next = S_FETCH;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_ctrl    <= state_outputs(S_FETCH, ALU_ADD);
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_ctrl    <= state_outputs(w_next, w_exec_alu);
            r_illegal <= r_illegal | w_illegal_set;
        end
    end

    // Write strobes are masked while reset is held; the FETCH strobes appear as soon as it lifts.
    logic w_pc_write;
    logic w_branch;
    assign w_pc_write = r_ctrl.pc_write & rst_n;
    assign w_branch   = r_ctrl.branch & rst_n;

    assign io_ctrl.IorD       = r_ctrl.iord;
    assign io_ctrl.MemWrite   = r_ctrl.mem_write & rst_n;
    assign io_ctrl.IRWrite    = r_ctrl.ir_write & rst_n;
    assign io_ctrl.PCWrite    = w_pc_write;
    assign io_ctrl.Branch     = w_branch;
    assign io_ctrl.PCEn       = w_pc_write | (w_branch & io_ctrl.zero);
    assign io_ctrl.ALUSrcA    = r_ctrl.alu_src_a;
    assign io_ctrl.RegDst     = r_ctrl.reg_dst;
    assign io_ctrl.MemtoReg   = r_ctrl.mem_to_reg;
    assign io_ctrl.RegWrite   = r_ctrl.reg_write & rst_n;
    assign io_ctrl.IllegalOp  = r_illegal;
    assign io_ctrl.ALUSrcB    = r_ctrl.alu_src_b;
    assign io_ctrl.PCSrc      = r_ctrl.pc_src;
    assign io_ctrl.ALUControl = r_ctrl.alu_ctrl;

endmodule
